// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    DONE,
    ERR
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_SHIFT     = 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LANE_W         = 2;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer; the completed word is presented
// combinationally alongside the byte that finishes it.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_byte_en,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_word_c,
  output logic              o_word_valid_c
);

  logic [WORD_W-BYTE_W-1:0] r_shift;
  logic [LANE_W-1:0]        r_lane;

  // Newest byte lands in the top lane; after four bytes byte 0 sits at [7:0].
  assign o_word_c       = {i_byte, r_shift};
  assign o_word_valid_c = i_byte_en && (r_lane == LANE_W'(BYTES_PER_WORD - 1));

  // Shift-in register and lane counter; the lane counter wraps per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_lane  <= '0;
    end else if (i_clr) begin
      r_shift <= '0;
      r_lane  <= '0;
    end else if (i_byte_en) begin
      r_shift <= o_word_c[WORD_W-1:BYTE_W];
      r_lane  <= r_lane + LANE_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte image and writes it word by
// word into the instruction memory, holding the CPU in reset until complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_s_valid,
  input  logic [BYTE_W-1:0] i_s_data,
  output logic              o_s_ready,
  output logic              o_wr_en,
  output logic [WORD_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_len
);

  localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_n;
  logic              r_s_ready;
  logic              r_wr_en;
  logic [WORD_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err_len;

  logic              w_accept;
  logic              w_start_ok;
  logic [WORD_W-1:0] w_word;
  logic              w_word_valid;
  logic [IDX_W-1:0]  w_idx_nxt;

  assign w_accept   = i_s_valid && r_s_ready;
  assign w_start_ok = i_start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_idx_nxt  = r_idx + IDX_W'(1);

  imem_loader_word_packer u_packer (
    .clk            (clk),
    .rst            (rst),
    .i_clr          (w_start_ok),
    .i_byte_en      (w_accept),
    .i_byte         (i_s_data),
    .o_word_c       (w_word),
    .o_word_valid_c (w_word_valid)
  );

  // Loader FSM with write-port registers and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_n        <= '0;
      r_s_ready  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= BASE_ADDR;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_len  <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            r_state    <= HDR;
            r_idx      <= '0;
            r_s_ready  <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err_len  <= 1'b0;
            r_cpu_hold <= 1'b1;
          end
        end
        HDR: begin
          if (w_word_valid) begin
            if (w_word == '0) begin
              r_state    <= DONE;
              r_s_ready  <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_word > WORD_W'(DEPTH)) begin
              r_state   <= ERR;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b0;
              r_err_len <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_n     <= IDX_W'(w_word);
            end
          end
        end
        LOAD: begin
          if (w_word_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= BASE_ADDR + (WORD_W'(r_idx) << WORD_SHIFT);
            r_wr_data <= w_word;
            r_idx     <= w_idx_nxt;
            if (w_idx_nxt == r_n) begin
              r_state    <= DONE;
              r_s_ready  <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s_ready  = r_s_ready;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_cpu_hold = r_cpu_hold;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err_len  = r_err_len;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write sequence, header edge cases,
// stalls, mid-load reset and restart behaviour.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_s_valid;
  logic [7:0]  i_s_data;
  logic        o_s_ready;
  logic        o_wr_en;
  logic [31:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_cpu_hold;
  logic        o_busy;
  logic        o_done;
  logic        o_err_len;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          wq_delta[$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;

  imem_loader #(.DEPTH(64), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_s_valid  (i_s_valid),
    .i_s_data   (i_s_data),
    .o_s_ready  (o_s_ready),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err_len  (o_err_len)
  );

  always #5 clk = ~clk;

  // Write monitor: logs writes and their distance from the last word-completing byte.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_wr_en) begin
      wq_addr.push_back(o_wr_addr);
      wq_data.push_back(o_wr_data);
      wq_delta.push_back(cyc - last_acc_cyc);
    end
    if (i_s_valid && o_s_ready) begin
      if (acc_cnt >= 4 && (acc_cnt % 4) == 3) last_acc_cyc = cyc;
      acc_cnt = acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < wq_addr.size()) ? wq_addr[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] qd(input int i);
    return (i < wq_data.size()) ? wq_data[i] : 32'hDEAD_DEAD;
  endfunction

  function automatic logic [31:0] qdl(input int i);
    return (i < wq_delta.size()) ? 32'(wq_delta[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_delta.delete();
    acc_cnt = 0;
  endtask

  task automatic pulse_start();
    clear_log();
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    i_s_valid = 1'b1;
    i_s_data  = b;
    for (int g = 0; g < 20 && !ok; g++) begin
      @(negedge clk);
      ok = o_s_ready;
      @(posedge clk); #1;
    end
    if (!ok) check("stall_timeout", 32'd0, 32'd1);
    i_s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_s_ready"}, 32'(o_s_ready), 32'd0);
    check({pfx, "_wr_en"},   32'(o_wr_en),   32'd0);
    check({pfx, "_wr_addr"}, o_wr_addr,      32'h0);
    check({pfx, "_wr_data"}, o_wr_data,      32'h0);
    check({pfx, "_hold"},    32'(o_cpu_hold), 32'd1);
    check({pfx, "_busy"},    32'(o_busy),    32'd0);
    check({pfx, "_done"},    32'(o_done),    32'd0);
    check({pfx, "_err"},     32'(o_err_len), 32'd0);
  endtask

  task automatic check_t1_writes(input string pfx);
    check({pfx, "_nwr"}, 32'(wq_addr.size()), 32'd2);
    check({pfx, "_a0"},  qa(0), 32'h0000_0000);
    check({pfx, "_d0"},  qd(0), 32'h0000_0013);
    check({pfx, "_a1"},  qa(1), 32'h0000_0004);
    check({pfx, "_d1"},  qd(1), 32'h01C8_06B3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_s_valid = 1'b0;
    i_s_data  = 8'h00;
    #12;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: two-word image
    pulse_start();
    check("t1_busy", 32'(o_busy), 32'd1);
    check("t1_rdy",  32'(o_s_ready), 32'd1);
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h01C8_06B3, 0);
    settle();
    check_t1_writes("t1");
    check("t1_dly0", qdl(0), 32'd1);
    check("t1_dly1", qdl(1), 32'd1);
    check("t1_done", 32'(o_done), 32'd1);
    check("t1_hold", 32'(o_cpu_hold), 32'd0);
    check("t1_rdy_end", 32'(o_s_ready), 32'd0);
    check("t1_busy_end", 32'(o_busy), 32'd0);

    // Test 2: empty image
    pulse_start();
    send_word(32'd0, 0);
    settle();
    check("t2_nwr",  32'(wq_addr.size()), 32'd0);
    check("t2_done", 32'(o_done), 32'd1);
    check("t2_hold", 32'(o_cpu_hold), 32'd0);

    // Test 3: oversize header, then recovery
    pulse_start();
    send_word(32'd65, 0);
    settle();
    check("t3_err",  32'(o_err_len), 32'd1);
    check("t3_rdy",  32'(o_s_ready), 32'd0);
    check("t3_hold", 32'(o_cpu_hold), 32'd1);
    check("t3_done", 32'(o_done), 32'd0);
    check("t3_nwr",  32'(wq_addr.size()), 32'd0);
    pulse_start();
    check("t3_err_clr", 32'(o_err_len), 32'd0);
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h01C8_06B3, 0);
    settle();
    check_t1_writes("t3r");
    check("t3r_done", 32'(o_done), 32'd1);

    // Test 4: same stream with random valid gaps
    pulse_start();
    send_word(32'd2, 3);
    send_word(32'h0000_0013, 3);
    send_word(32'h01C8_06B3, 3);
    settle();
    check_t1_writes("t4");
    check("t4_dly0", qdl(0), 32'd1);
    check("t4_dly1", qdl(1), 32'd1);
    check("t4_done", 32'(o_done), 32'd1);

    // Test 5: reset part-way through a three-word image
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'h4433_2211, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    settle();
    check("t5_nwr", 32'(wq_addr.size()), 32'd1);
    check("t5_a0",  qa(0), 32'h0000_0000);
    check("t5_d0",  qd(0), 32'h4433_2211);
    check("t5_busy_pre", 32'(o_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t5rst");
    @(posedge clk); #1;
    rst = 1'b0;
    settle();
    check("t5_nwr_rst", 32'(wq_addr.size()), 32'd1);
    pulse_start();
    send_word(32'd3, 0);
    send_word(32'hAAAA_0001, 0);
    send_word(32'hBBBB_0002, 0);
    send_word(32'hCCCC_0003, 0);
    settle();
    check("t5r_nwr", 32'(wq_addr.size()), 32'd3);
    check("t5r_a0",  qa(0), 32'h0000_0000);
    check("t5r_d0",  qd(0), 32'hAAAA_0001);
    check("t5r_a2",  qa(2), 32'h0000_0008);
    check("t5r_d2",  qd(2), 32'hCCCC_0003);
    check("t5r_done", 32'(o_done), 32'd1);

    // Test 6: start ignored while loading; restart from DONE
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    @(posedge clk); #1;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check("t6_busy_mid", 32'(o_busy), 32'd1);
    send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    send_word(32'h9ABC_DEF0, 0);
    settle();
    check("t6_nwr", 32'(wq_addr.size()), 32'd2);
    check("t6_d0",  qd(0), 32'h1234_5678);
    check("t6_a1",  qa(1), 32'h0000_0004);
    check("t6_d1",  qd(1), 32'h9ABC_DEF0);
    check("t6_done", 32'(o_done), 32'd1);
    pulse_start();
    check("t6_hold_rs", 32'(o_cpu_hold), 32'd1);
    check("t6_busy_rs", 32'(o_busy), 32'd1);
    check("t6_done_rs", 32'(o_done), 32'd0);
    send_word(32'd1, 0);
    send_word(32'hDEAD_BEEF, 0);
    settle();
    check("t6r_nwr", 32'(wq_addr.size()), 32'd1);
    check("t6r_a0",  qa(0), 32'h0000_0000);
    check("t6r_d0",  qd(0), 32'hDEAD_BEEF);
    check("t6r_done", 32'(o_done), 32'd1);
    check("t6r_hold", 32'(o_cpu_hold), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
